// File: rtl/bop_pkg.sv
// Shared constants and types for the best-offset prefetcher and its delay queue.
package bop_pkg;

  localparam int unsigned DELAYQSIZE = 15;
  localparam int unsigned DELAY      = 60;
  localparam int unsigned TIME_BITS  = 12;
  localparam int unsigned ADDR_WIDTH = 64;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] data;
    logic [TIME_BITS-1:0]  ts;
    logic                  valid;
    logic                  mature;
  } dq_entry_t;

endpackage

// File: rtl/bop_delay_queue.sv
// Timed FIFO feeding the best-offset prefetcher's RR table: entries reach the head
// no sooner than DELAY cycles after being pushed.
module bop_delay_queue #(
  parameter int unsigned WIDTH     = bop_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH     = bop_pkg::DELAYQSIZE,
  parameter int unsigned DELAY     = bop_pkg::DELAY,
  parameter int unsigned TIME_BITS = bop_pkg::TIME_BITS,
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cq_enq,
  input  logic             cq_deq,
  input  logic [WIDTH-1:0] cq_in,
  output logic             cq_empty,
  output logic             cq_full,
  output logic             cq_ready,
  output logic [WIDTH-1:0] cq_out,
  output logic [CntW-1:0]  cq_count,
  output logic             cq_drop
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TIME_BITS-1:0] DelayT  = TIME_BITS'(DELAY);
  localparam logic [PtrW-1:0]      LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0]      FullCnt = CntW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [TIME_BITS-1:0] ts;
    logic                 valid;
    logic                 mature;
  } entry_t;

  entry_t               ent_q [DEPTH];
  entry_t               ent_d [DEPTH];
  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [TIME_BITS-1:0] now_q;
  logic                 drop_q;
  logic [DEPTH-1:0]     elig;
  logic                 pop, drop;

  // Sticky mature bit keeps long-held entries eligible after the age wraps.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    logic [TIME_BITS-1:0] age;
    assign age     = now_q - ent_q[i].ts;
    assign elig[i] = ent_q[i].valid & (ent_q[i].mature | (age >= DelayT));
  end

  assign cq_ready = elig[head_q];
  assign cq_empty = (count_q == '0);
  assign cq_full  = (count_q == FullCnt);
  assign cq_count = count_q;
  assign cq_drop  = drop_q;
  assign cq_out   = ent_q[head_q].valid ? ent_q[head_q].data : '0;

  always_comb begin
    pop     = cq_deq & cq_ready;
    drop    = cq_enq & cq_full & ~pop;
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].mature = elig[i];
    end

    if (pop || drop) begin
      ent_d[head_q].valid  = 1'b0;
      ent_d[head_q].mature = 1'b0;
      head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
    end

    // When full, head == tail, so the write below reuses the slot just freed.
    if (cq_enq) begin
      ent_d[tail_q] = '{data: cq_in, ts: now_q, valid: 1'b1, mature: 1'b0};
      tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);
    end

    if (cq_enq && !pop && !cq_full) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !cq_enq) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      now_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid  <= 1'b0;
        ent_q[i].mature <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      now_q   <= now_q + TIME_BITS'(1);
      drop_q  <= drop;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule
